// File: rtl/divide8_signed_sequential_if.sv
// rtl/divide8_signed_sequential_if.sv - start/busy/done handshake and operand/result bundle for the signed divider
// The controller drives start and operands; the divider returns results and flags.
interface divide8_signed_sequential_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/divide8_signed_sequential.sv
// rtl/divide8_signed_sequential.sv - iterative signed restoring divider, one quotient bit per clock
// Optional DIVIDE8_ZERO_EARLY_EN: a zero divisor skips the CALC steps and finishes in one clock.
module divide8_signed_sequential #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    divide8_signed_sequential_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             q_sign;
    logic             r_sign;
    logic             zero_div;
    logic             ovf_case;
    logic [WIDTH-1:0] dvd_raw;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH:0]   dvs_mag;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] quo_res;
    logic [WIDTH-1:0] rem_res;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             done_r;
    logic             dbz_r;
    logic             ovf_r;
    logic             divisor_zero;

    // Magnitudes are taken as unsigned, so |-128| lands as 8'h80 = 128.
    assign dvd_abs      = bus.dividend[WIDTH-1] ? ({WIDTH{1'b0}} - bus.dividend) : bus.dividend;
    assign dvs_abs      = bus.divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - bus.divisor)  : bus.divisor;
    assign divisor_zero = (bus.divisor == {WIDTH{1'b0}});

    assign shifted = {part_rem, dvd_sh[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_mag};
    assign quo_res = q_sign ? ({WIDTH{1'b0}} - quo_sh) : quo_sh;
    assign rem_res = r_sign ? ({WIDTH{1'b0}} - part_rem[WIDTH-1:0]) : part_rem[WIDTH-1:0];

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef DIVIDE8_ZERO_EARLY_EN
                    state_next = divisor_zero ? FIX : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            q_sign      <= 1'b0;
            r_sign      <= 1'b0;
            zero_div    <= 1'b0;
            ovf_case    <= 1'b0;
            dvd_raw     <= '0;
            dvd_sh      <= '0;
            quo_sh      <= '0;
            dvs_mag     <= '0;
            part_rem    <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        q_sign   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        r_sign   <= bus.dividend[WIDTH-1];
                        dvd_raw  <= bus.dividend;
                        dvd_sh   <= dvd_abs;
                        dvs_mag  <= {1'b0, dvs_abs};
                        zero_div <= divisor_zero;
                        ovf_case <= (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.divisor);
                        part_rem <= '0;
                        quo_sh   <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    // A negative trial difference means restore: keep the shifted value.
                    part_rem <= diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
                    quo_sh   <= {quo_sh[WIDTH-2:0], ~diff[WIDTH+1]};
                    dvd_sh   <= {dvd_sh[WIDTH-2:0], 1'b0};
                    cnt      <= cnt + 1'b1;
                end
                FIX: begin
                    done_r <= 1'b1;
                    if (zero_div) begin
                        quotient_r  <= {WIDTH{1'b1}};
                        remainder_r <= dvd_raw;
                        dbz_r       <= 1'b1;
                        ovf_r       <= 1'b0;
                    end else begin
                        quotient_r  <= quo_res;
                        remainder_r <= rem_res;
                        dbz_r       <= 1'b0;
                        ovf_r       <= ovf_case;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
